// File: rtl/phase_scheduler.sv
// Round-robin signal phase scheduler for a four-phase intersection.
// Latches requests, grants one green at a time, and inserts yellow and all-red clearance with min/max green timing.
module phase_scheduler #(
    parameter int MIN_GREEN = 8,
    parameter int MAX_GREEN = 32,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 2,
    parameter int CNT_W     = 6
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pedestrian_req,
    input  logic       up_req,
    input  logic       down_req,
    input  logic       turn_req,
    output logic       pedestrian_green,
    output logic       up_green,
    output logic       down_green,
    output logic       turn_green,
    output logic       yellow,
    output logic       all_red,
    output logic [1:0] active_phase
);

    typedef enum logic [1:0] {
        ST_RED   = 2'd0,
        ST_GREEN = 2'd1,
        ST_YEL   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_RED_END = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] C_MIN_END = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] C_MAX_END = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] C_YEL_END = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_pending;
    logic [3:0]       r_green;
    logic [1:0]       r_last;
    logic             r_yellow;
    logic             r_all_red;

    logic [3:0]       w_req;
    logic [3:0]       w_cand;
    logic [3:0]       w_other;
    logic [3:0]       w_grant_mask;
    logic [1:0]       w_order [4];
    logic [1:0]       w_winner;
    logic             w_grant;
    logic             w_leave_green;

    assign w_req  = {turn_req, down_req, up_req, pedestrian_req};
    assign w_cand = r_pending | w_req;

    // Search order starts just after the last served phase and ends on it.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_order
            assign w_order[gi] = r_last + 2'(gi + 1);
        end
    endgenerate

    always_comb begin
        w_winner = r_last;
        for (int k = 3; k >= 0; k--) begin
            if (w_cand[w_order[k]]) begin
                w_winner = w_order[k];
            end
        end
    end

    assign w_grant       = (r_state == ST_RED) && (r_cnt == C_RED_END) && (w_cand != 4'b0000);
    assign w_grant_mask  = w_grant ? (4'b0001 << w_winner) : 4'b0000;

    // In GREEN r_last is the phase being served, so it is excluded from competition.
    assign w_other       = w_cand & ~(4'b0001 << r_last);
    assign w_leave_green = (w_other != 4'b0000) &&
                           (((r_cnt >= C_MIN_END) && !w_req[r_last]) || (r_cnt == C_MAX_END));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_RED;
            r_cnt     <= '0;
            r_pending <= 4'b0000;
            r_last    <= 2'd3;
            r_green   <= 4'b0000;
            r_yellow  <= 1'b0;
            r_all_red <= 1'b1;
        end else begin
            // A request on the granting edge of its own phase is dropped.
            r_pending <= w_cand & ~w_grant_mask;

            case (r_state)
                ST_RED: begin
                    if (r_cnt == C_RED_END) begin
                        if (w_grant) begin
                            r_state   <= ST_GREEN;
                            r_cnt     <= '0;
                            r_last    <= w_winner;
                            r_green   <= w_grant_mask;
                            r_all_red <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end

                ST_GREEN: begin
                    if (w_leave_green) begin
                        r_state  <= ST_YEL;
                        r_cnt    <= '0;
                        r_green  <= 4'b0000;
                        r_yellow <= 1'b1;
                    end else if (r_cnt != C_MAX_END) begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end

                ST_YEL: begin
                    if (r_cnt == C_YEL_END) begin
                        r_state   <= ST_RED;
                        r_cnt     <= '0;
                        r_yellow  <= 1'b0;
                        r_all_red <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end

                default: begin
                    r_state   <= ST_RED;
                    r_cnt     <= '0;
                    r_green   <= 4'b0000;
                    r_yellow  <= 1'b0;
                    r_all_red <= 1'b1;
                end
            endcase
        end
    end

    assign pedestrian_green = r_green[0];
    assign up_green         = r_green[1];
    assign down_green       = r_green[2];
    assign turn_green       = r_green[3];
    assign yellow           = r_yellow;
    assign all_red          = r_all_red;
    assign active_phase     = r_last;

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed testbench for phase_scheduler: a table of per-cycle vectors plus
// hand-written sequences for max-green rotation and asynchronous reset during yellow.
module tb_phase_scheduler;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       ped_r = 1'b0, up_r = 1'b0, down_r = 1'b0, turn_r = 1'b0;
    logic       pg, ug, dg, tg, yel, ared;
    logic [1:0] act;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    phase_scheduler #(
        .MIN_GREEN(8),
        .MAX_GREEN(32),
        .YELLOW   (3),
        .ALL_RED  (2),
        .CNT_W    (6)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .pedestrian_req  (ped_r),
        .up_req          (up_r),
        .down_req        (down_r),
        .turn_req        (turn_r),
        .pedestrian_green(pg),
        .up_green        (ug),
        .down_green      (dg),
        .turn_green      (tg),
        .yellow          (yel),
        .all_red         (ared),
        .active_phase    (act)
    );

    // One record covers `reps` consecutive cycles with the same inputs and expected outputs.
    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic [3:0] grn;
        logic       yel;
        logic       ared;
        logic [1:0] act;
        int         reps;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, logic [3:0] req, logic [3:0] grn,
                                logic y, logic ar, logic [1:0] a, int reps);
        vec_t v;
        v.rst = rst; v.req = req; v.grn = grn; v.yel = y; v.ared = ar; v.act = a; v.reps = reps;
        return v;
    endfunction

    function automatic logic [7:0] outs();
        return {tg, dg, ug, pg, yel, ared, act};
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got grn=%b yel=%b ared=%b act=%0d, expected grn=%b yel=%b ared=%b act=%0d",
                     name, got[7:4], got[3], got[2], got[1:0], exp_v[7:4], exp_v[3], exp_v[2], exp_v[1:0]);
        end
    endtask

    task automatic set_req(input logic [3:0] r);
        {turn_r, down_r, up_r, ped_r} = r;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_req(4'b0000);
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", outs(), {4'b0000, 1'b0, 1'b1, 2'd3});
        reset_n = 1'b1;
    endtask

    // Invariants: at most one green, no direct green-to-green handover, one-hot output class.
    logic [3:0] mon_g;
    logic [3:0] prev_g = 4'b0000;
    always @(negedge clock) begin
        mon_g = {tg, dg, ug, pg};
        if (reset_n) begin
            n_checks++;
            if ($countones(mon_g) > 1 ||
                (prev_g != 4'b0000 && mon_g != 4'b0000 && mon_g != prev_g) ||
                $countones({|mon_g, yel, ared}) != 1) begin
                n_fail++;
                $display("FAIL invariant at %0t: grn=%b prev=%b yel=%b ared=%b", $time, mon_g, prev_g, yel, ared);
            end
        end
        prev_g = mon_g;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_v;
        int         t, n, ph;

        // Idle after reset: all-red forever.
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 1, 2'd3, 20));
        // up pulse sampled at edge 5, rest in green, down pulse after min green forces handover.
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 1, 2'd3, 4));
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 0, 0, 2'd1, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0010, 0, 0, 2'd1, 14));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 1, 0, 2'd1, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 2'd1, 2));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 2'd1, 2));
        tbl.push_back(mk(0, 4'b0000, 4'b0100, 0, 0, 2'd2, 3));
        // Turn green, ped pulse while turn drops: min green 8, then turn->ped, then back to pending turn.
        tbl.push_back(mk(1, 4'b1000, 4'b0000, 0, 1, 2'd3, 1));
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 0, 0, 2'd3, 3));
        tbl.push_back(mk(0, 4'b0001, 4'b1000, 0, 0, 2'd3, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b1000, 0, 0, 2'd3, 4));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 2'd3, 3));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 2'd3, 2));
        tbl.push_back(mk(0, 4'b0000, 4'b0001, 0, 0, 2'd0, 8));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 2'd0, 3));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 2'd0, 2));
        tbl.push_back(mk(0, 4'b0000, 4'b1000, 0, 0, 2'd3, 2));

        do_reset();

        for (int r = 0; r < tbl.size(); r++) begin
            if (tbl[r].rst) do_reset();
            $display("row %0d: req=%b expect grn=%b yel=%b ared=%b act=%0d for %0d cycles",
                     r, tbl[r].req, tbl[r].grn, tbl[r].yel, tbl[r].ared, tbl[r].act, tbl[r].reps);
            for (int c = 0; c < tbl[r].reps; c++) begin
                set_req(tbl[r].req);
                step();
                check($sformatf("vec_row%0d_cyc%0d", r, c), outs(),
                      {tbl[r].grn, tbl[r].yel, tbl[r].ared, tbl[r].act});
            end
        end

        // All four requests held: each green runs to max, 37-cycle period, order ped,up,down,turn,ped.
        do_reset();
        set_req(4'b1111);
        $display("seq all_held: 155 cycles");
        for (int e = 1; e <= 155; e++) begin
            step();
            if (e < 2) begin
                exp_v = {4'b0000, 1'b0, 1'b1, 2'd3};
            end else begin
                t  = (e - 2) % 37;
                n  = (e - 2) / 37;
                ph = n % 4;
                if (t < 32)      exp_v = {4'(1 << ph), 1'b0, 1'b0, 2'(ph)};
                else if (t < 35) exp_v = {4'b0000, 1'b1, 1'b0, 2'(ph)};
                else             exp_v = {4'b0000, 1'b0, 1'b1, 2'(ph)};
            end
            check($sformatf("all_held_e%0d", e), outs(), exp_v);
        end

        // Asynchronous reset in the middle of a yellow cycle.
        do_reset();
        set_req(4'b0110);
        $display("seq async_reset_in_yellow");
        step();
        check("ay_red_e1", outs(), {4'b0000, 1'b0, 1'b1, 2'd3});
        set_req(4'b0000);
        step();
        check("ay_up_green", outs(), {4'b0010, 1'b0, 1'b0, 2'd1});
        repeat (8) step();
        check("ay_yellow_e10", outs(), {4'b0000, 1'b1, 1'b0, 2'd1});
        step();
        check("ay_yellow_e11", outs(), {4'b0000, 1'b1, 1'b0, 2'd1});
        #2 reset_n = 1'b0;
        #1 check("ay_async_reset", outs(), {4'b0000, 1'b0, 1'b1, 2'd3});
        #2 reset_n = 1'b1;
        set_req(4'b0001);
        step();
        check("ay_post_red", outs(), {4'b0000, 1'b0, 1'b1, 2'd3});
        step();
        check("ay_post_grant", outs(), {4'b0001, 1'b0, 1'b0, 2'd0});
        set_req(4'b0000);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
